// File: rtl/vector_sequencer.sv
// vector_sequencer: steps a 4-bit transform unit through a code table,
// holding each code HOLD cycles and reporting each captured output.
module vector_sequencer #(
  parameter  int DEPTH = 8,
  parameter  int HOLD  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [3:0]    i_wr_data,
  input  logic [3:0]    i_len,
  input  logic          i_start,
  input  logic          i_abort,
  output logic [3:0]    o_dut_in,
  input  logic [3:0]    i_dut_out,
  output logic          o_busy,
  output logic          o_res_valid,
  output logic [AW-1:0] o_res_idx,
  output logic [3:0]    o_res_data,
  output logic [3:0]    o_res_xor,
  output logic          o_done
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_tbl [DEPTH];
  logic [3:0]    r_dut_in;
  logic [3:0]    r_res_data;
  logic [3:0]    r_res_xor;
  logic [AW-1:0] r_res_idx;
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [AW:0]   r_len;
  logic          r_res_valid;
  logic          r_done;

  logic [AW:0]   w_len_eff;
  logic          w_go;
  logic          w_empty;
  logic          w_dec;
  logic          w_cap;
  logic          w_last;
  logic          w_adv;

  assign w_len_eff = (int'(i_len) > DEPTH) ? LEN_MAX
                   : (AW+1)'(i_len);

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_empty     = 1'b0;
    w_dec       = 1'b0;
    w_cap       = 1'b0;
    w_last      = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_len_eff != '0) begin
            w_go        = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_empty = 1'b1;
          end
        end
      end
      S_RUN: begin
        // abort outranks both the countdown and the capture
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_dec = 1'b1;
        end else begin
          w_cap = 1'b1;
          if ({1'b0, r_idx} == r_len - LEN_ONE) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // the start edge reads entry 0 before any same-edge write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (i_wr_en && (r_state == S_IDLE)) begin
      r_tbl[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_in    <= '0;
      r_res_data  <= '0;
      r_res_xor   <= '0;
      r_res_idx   <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_go) begin
        r_idx     <= '0;
        r_cnt     <= CNT_LOAD;
        r_dut_in  <= r_tbl[0];
        r_res_xor <= '0;
        r_len     <= w_len_eff;
      end
      if (w_empty) begin
        r_done    <= 1'b1;
        r_res_xor <= '0;
      end
      if (w_dec) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_cap) begin
        r_res_data  <= i_dut_out;
        r_res_idx   <= r_idx;
        r_res_valid <= 1'b1;
        r_res_xor   <= r_res_xor ^ i_dut_out;
      end
      if (w_last) begin
        r_done <= 1'b1;
      end
      if (w_adv) begin
        r_idx    <= r_idx + IDX_ONE;
        r_dut_in <= r_tbl[r_idx + IDX_ONE];
        r_cnt    <= CNT_LOAD;
      end
    end
  end

  assign o_dut_in    = r_dut_in;
  assign o_busy      = (r_state == S_RUN);
  assign o_res_valid = r_res_valid;
  assign o_res_idx   = r_res_idx;
  assign o_res_data  = r_res_data;
  assign o_res_xor   = r_res_xor;
  assign o_done      = r_done;

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: randomized scenarios against a table/schedule model,
// transform unit modelled as out = ~in.
module tb_vector_sequencer;

  localparam int DEPTH = 8;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] dut_in;
  logic [3:0] dut_out;
  logic       busy;
  logic       res_valid;
  logic [2:0] res_idx;
  logic [3:0] res_data;
  logic [3:0] res_xor;
  logic       done;

  logic [3:0] m_tbl [DEPTH];
  logic [3:0] m_dut_in;
  logic [3:0] m_xor;
  int n_err = 0;
  int n_chk = 0;

  vector_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_len      (len),
    .i_start    (start),
    .i_abort    (abort),
    .o_dut_in   (dut_in),
    .i_dut_out  (dut_out),
    .o_busy     (busy),
    .o_res_valid(res_valid),
    .o_res_idx  (res_idx),
    .o_res_data (res_data),
    .o_res_xor  (res_xor),
    .o_done     (done)
  );

  assign dut_out = ~dut_in;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    m_tbl[a] = d;
  endtask

  task automatic do_run(input string tag, input int ln, input bit noise,
                        input bit hold, input bit wr0, input logic [3:0] wd);
    int le;
    int tot;
    int k;
    logic [3:0] code [DEPTH];
    logic [3:0] ex_in;
    logic [3:0] x;
    logic ev;
    le = (ln > DEPTH) ? DEPTH : ln;
    for (int i = 0; i < DEPTH; i++) code[i] = m_tbl[i];
    len   = 4'(ln);
    start = 1'b1;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = wd;
    end
    tick();
    if (!hold) start = 1'b0;
    if (wr0) begin
      wr_en = 1'b0;
      m_tbl[0] = wd;
    end
    if (le == 0) begin
      n_chk++;
      if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
          res_xor !== 4'd0 || dut_in !== m_dut_in) begin
        n_err++;
        $display("FAIL %s empty: done=%b busy=%b vld=%b xor=%0d in=%0d want 1 0 0 0 %0d",
                 tag, done, busy, res_valid, res_xor, dut_in, m_dut_in);
      end
      m_xor = '0;
      tick();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s empty_after: done=%b busy=%b want 0 0", tag, done, busy);
      end
      return;
    end
    tot = le * HOLD;
    x = '0;
    n_chk++;
    if (busy !== 1'b1 || dut_in !== code[0] || res_valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s launch: busy=%b in=%0d vld=%b done=%b want 1 %0d 0 0",
               tag, busy, dut_in, res_valid, done, code[0]);
    end
    for (int c = 1; c <= tot; c++) begin
      if (noise) begin
        wr_en = 1'b1;
        wr_addr = 3'($urandom_range(0, 7));
        wr_data = 4'($urandom_range(0, 15));
      end
      tick();
      wr_en = 1'b0;
      ev = (c % HOLD) == 0;
      ex_in = code[((c == tot) ? c - 1 : c) / HOLD];
      if (ev) x = x ^ ~code[c / HOLD - 1];
      n_chk++;
      if (res_valid !== ev || busy !== (c < tot) || done !== (c == tot) ||
          dut_in !== ex_in || res_xor !== x) begin
        n_err++;
        $display("FAIL %s cyc%0d: vld=%b busy=%b done=%b in=%0d xor=%0d want %b %b %b %0d %0d",
                 tag, c, res_valid, busy, done, dut_in, res_xor,
                 ev, c < tot, c == tot, ex_in, x);
      end
      if (ev) begin
        k = c / HOLD - 1;
        n_chk++;
        if (res_idx !== 3'(k) || res_data !== ~code[k]) begin
          n_err++;
          $display("FAIL %s result%0d: idx=%0d data=%0d want %0d %0d",
                   tag, k, res_idx, res_data, k, ~code[k]);
        end
      end
    end
    m_dut_in = code[le - 1];
    m_xor = x;
  endtask

  task automatic load_t1();
    wr(0, 4'd12);
    wr(1, 4'd10);
    wr(2, 4'd4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || dut_in !== 4'd0 ||
        res_idx !== 3'd0 || res_data !== 4'd0 || res_xor !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b vld=%b done=%b in=%0d idx=%0d data=%0d xor=%0d want all 0",
               busy, res_valid, done, dut_in, res_idx, res_data, res_xor);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
    m_dut_in = '0;
    m_xor = '0;
    tick();
  endtask

  task automatic test_basic();
    load_t1();
    do_run("basic", 3, 1'b0, 1'b0, 1'b0, '0);
    n_chk++;
    if (res_xor !== 4'd13 || res_data !== 4'd11) begin
      n_err++;
      $display("FAIL basic_const: xor=%0d data=%0d want 13 11", res_xor, res_data);
    end
    tick();
  endtask

  task automatic test_len_zero();
    do_run("len0", 0, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_abort();
    load_t1();
    len = 4'd3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || dut_in !== 4'd12) begin
      n_err++;
      $display("FAIL abort_startwins: busy=%b in=%0d want 1 12", busy, dut_in);
    end
    for (int c = 1; c <= 6; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || dut_in !== 4'd10 ||
        res_idx !== 3'd0 || res_data !== 4'd3 || res_xor !== 4'd3) begin
      n_err++;
      $display("FAIL abort_state: busy=%b vld=%b done=%b in=%0d idx=%0d data=%0d xor=%0d want 0 0 0 10 0 3 3",
               busy, res_valid, done, dut_in, res_idx, res_data, res_xor);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_chk++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet%0d: busy=%b vld=%b done=%b want 0 0 0",
                 c, busy, res_valid, done);
      end
    end
    m_dut_in = 4'd10;
    do_run("abort_rerun", 3, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_clamp();
    for (int a = 0; a < DEPTH; a++) wr(a, 4'($urandom_range(0, 15)));
    do_run("clamp_noise", 12, 1'b1, 1'b0, 1'b0, '0);
    tick();
    do_run("clamp_rerun", 12, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_reset_midrun();
    load_t1();
    len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || dut_in !== 4'd0 || res_data !== 4'd0 ||
        res_idx !== 3'd0 || res_xor !== 4'd0 || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: busy=%b in=%0d data=%0d idx=%0d xor=%0d vld=%b want all 0",
               busy, dut_in, res_data, res_idx, res_xor, res_valid);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
    m_dut_in = '0;
    m_xor = '0;
    tick();
    do_run("rst_rerun", 3, 1'b0, 1'b0, 1'b0, '0);
    n_chk++;
    if (res_xor !== 4'd15 || res_data !== 4'd15) begin
      n_err++;
      $display("FAIL rst_const: xor=%0d data=%0d want 15 15", res_xor, res_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    load_t1();
    do_run("held_a", 3, 1'b0, 1'b1, 1'b0, '0);
    do_run("held_b", 3, 1'b0, 1'b0, 1'b0, '0);
    n_chk++;
    if (res_xor !== 4'd13) begin
      n_err++;
      $display("FAIL held_const: xor=%0d want 13", res_xor);
    end
    tick();
  endtask

  task automatic test_write_on_start();
    wr(0, 4'd5);
    do_run("wos_a", 2, 1'b0, 1'b0, 1'b1, 4'd9);
    tick();
    do_run("wos_b", 2, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, 4'($urandom_range(0, 15)));
      do_run("rand", $urandom_range(0, 15), r[0], 1'b0, 1'b0, '0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_abort();
    test_clamp();
    test_reset_midrun();
    test_back_to_back();
    test_write_on_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
